// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt capture/dispatch blocks.
package irq_pkg;

    localparam int unsigned IRQ_N     = 8;
    localparam int unsigned IRQ_IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_state_e;

    // Highest-index-first encoder; returns {any, idx}.
    function automatic logic [IRQ_IDX_W:0] prio_enc(input logic [IRQ_N-1:0] vec);
        logic                 any;
        logic [IRQ_IDX_W-1:0] idx;
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < int'(IRQ_N); i++) begin
            if (vec[i]) begin
                any = 1'b1;
                idx = IRQ_IDX_W'(i);
            end
        end
        return {any, idx};
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder, bit 7 highest, with an any flag.
module prio_enc8
    import irq_pkg::*;
(
    input  logic [IRQ_N-1:0]     vec_i,
    output logic [IRQ_IDX_W-1:0] idx_o,
    output logic                 any_o
);

    always_comb begin
        {any_o, idx_o} = prio_enc(vec_i);
    end

endmodule

// File: rtl/irq_capture_encoder.sv
// Rising-edge request capture into sticky pending bits, with the highest
// unmasked pending index presented over a valid/ready handshake.
module irq_capture_encoder
    import irq_pkg::*;
#(
    parameter int unsigned N     = IRQ_N,
    parameter int unsigned IDX_W = IRQ_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             drop_pulse
);

    irq_state_e       state_q;
    logic [N-1:0]     req_q;
    logic [N-1:0]     pending_q;
    logic [N-1:0]     pending_d;
    logic [IDX_W-1:0] out_idx_q;
    logic             out_valid_q;
    logic             drop_q;
    logic             drop_d;

    logic [N-1:0]     edge_c;
    logic [N-1:0]     cand_c;
    logic [N-1:0]     clr_c;
    logic [IDX_W-1:0] sel_c;
    logic             sel_any_c;
    logic             load_c;

    assign edge_c = req_in & ~req_q;
    assign cand_c = pending_q & ~mask;

    prio_enc8 u_prio_enc8 (
        .vec_i (cand_c),
        .idx_o (sel_c),
        .any_o (sel_any_c)
    );

    // A new edge on the line being loaded keeps its pending bit set.
    always_comb begin
        load_c = 1'b0;
        case (state_q)
            IDLE:    load_c = sel_any_c;
            OFFER:   load_c = out_ready && sel_any_c;
            default: load_c = 1'b0;
        endcase
        clr_c     = load_c ? (N'(1) << sel_c) : '0;
        pending_d = (pending_q & ~clr_c) | edge_c;
        drop_d    = |(edge_c & pending_q & ~clr_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            pending_q   <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            req_q     <= req_in;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            case (state_q)
                IDLE: begin
                    if (sel_any_c) begin
                        out_idx_q   <= sel_c;
                        out_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    // A presented offer is held until accepted, never preempted.
                    if (out_ready) begin
                        if (sel_any_c) begin
                            out_idx_q <= sel_c;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_idx    = out_idx_q;
    assign out_valid  = out_valid_q;
    assign pending    = pending_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_irq_capture_encoder.sv
// Directed self-checking bench for irq_capture_encoder.
module tb_irq_capture_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       drop_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    irq_capture_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .mask       (mask),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pending    (pending),
        .drop_pulse (drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one clock and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_in    = 8'hFF;
        mask      = 8'h00;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_idx", 32'(out_idx), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_drop", 32'(drop_pulse), 32'h0);

        // Line held high through reset gives edges right after release
        rst = 1'b0;
        tick();
        check("por_pending", 32'(pending), 32'hFF);
        check("por_drop", 32'(drop_pulse), 32'h0);
        check("por_valid0", 32'(out_valid), 32'h0);
        tick();
        check("por_idx7", 32'(out_idx), 32'h7);
        check("por_valid", 32'(out_valid), 32'h1);
        check("por_pend7f", 32'(pending), 32'h7F);
        for (int i = 6; i >= 0; i--) begin
            tick();
            check($sformatf("por_drain%0d", i), 32'(out_idx), 32'(i));
            check($sformatf("por_dval%0d", i), 32'(out_valid), 32'h1);
        end
        tick();
        check("por_idle", 32'(out_valid), 32'h0);
        check("por_empty", 32'(pending), 32'h0);
        req_in = 8'h00;
        tick();
        tick();

        // Two-line burst with ready held
        req_in = 8'h24;
        tick();
        check("b_pend", 32'(pending), 32'h24);
        tick();
        check("b_idx5", 32'(out_idx), 32'h5);
        check("b_val5", 32'(out_valid), 32'h1);
        tick();
        check("b_idx2", 32'(out_idx), 32'h2);
        check("b_val2", 32'(out_valid), 32'h1);
        tick();
        check("b_idle", 32'(out_valid), 32'h0);
        check("b_empty", 32'(pending), 32'h0);
        check("b_idxhold", 32'(out_idx), 32'h2);
        req_in = 8'h00;
        tick();

        // Stall with a later higher-priority arrival that must not preempt
        out_ready = 1'b0;
        req_in    = 8'h81;
        tick();
        check("s_pend", 32'(pending), 32'h81);
        tick();
        check("s_idx7", 32'(out_idx), 32'h7);
        req_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req_in = 8'h10;
            tick();
            check($sformatf("s_hold_idx%0d", i), 32'(out_idx), 32'h7);
            check($sformatf("s_hold_val%0d", i), 32'(out_valid), 32'h1);
        end
        check("s_pend11", 32'(pending), 32'h11);
        out_ready = 1'b1;
        req_in    = 8'h00;
        tick();
        check("s_idx4", 32'(out_idx), 32'h4);
        tick();
        check("s_idx0", 32'(out_idx), 32'h0);
        check("s_val0", 32'(out_valid), 32'h1);
        tick();
        check("s_idle", 32'(out_valid), 32'h0);

        // Masked line stays pending until the mask is lifted
        mask   = 8'h08;
        req_in = 8'h0C;
        tick();
        tick();
        check("m_idx2", 32'(out_idx), 32'h2);
        check("m_pend", 32'(pending), 32'h08);
        tick();
        check("m_idle", 32'(out_valid), 32'h0);
        check("m_pend_keep", 32'(pending), 32'h08);
        mask   = 8'h00;
        req_in = 8'h00;
        tick();
        check("m_idx3", 32'(out_idx), 32'h3);
        check("m_val3", 32'(out_valid), 32'h1);
        tick();
        check("m_done", 32'(out_valid), 32'h0);

        // Second edge on an already pending, masked line
        mask   = 8'h02;
        req_in = 8'h02;
        tick();
        check("d_pend", 32'(pending), 32'h02);
        check("d_nodrop", 32'(drop_pulse), 32'h0);
        req_in = 8'h00;
        tick();
        req_in = 8'h02;
        tick();
        check("d_drop", 32'(drop_pulse), 32'h1);
        check("d_pend1", 32'(pending), 32'h02);
        tick();
        check("d_drop_end", 32'(drop_pulse), 32'h0);
        check("d_noval", 32'(out_valid), 32'h0);
        mask   = 8'h00;
        req_in = 8'h00;
        tick();
        check("d_idx1", 32'(out_idx), 32'h1);
        tick();
        check("d_idle", 32'(out_valid), 32'h0);

        // Edge on line 6 in the same cycle index 6 is loaded
        mask   = 8'h40;
        req_in = 8'h40;
        tick();
        req_in = 8'h00;
        tick();
        check("c_pend", 32'(pending), 32'h40);
        mask   = 8'h00;
        req_in = 8'h40;
        tick();
        check("c_idx6a", 32'(out_idx), 32'h6);
        check("c_pend_set", 32'(pending), 32'h40);
        check("c_nodrop", 32'(drop_pulse), 32'h0);
        tick();
        check("c_idx6b", 32'(out_idx), 32'h6);
        check("c_val6b", 32'(out_valid), 32'h1);
        check("c_empty", 32'(pending), 32'h00);
        tick();
        check("c_idle", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/irq_capture_encoder.md
Name: irq_capture_encoder

Overview:
- Registered request-capture and priority-encode stage for 8 discrete request lines.
- Detects rising edges on raw request lines and holds each as a sticky pending bit.
- Presents the highest-priority unmasked pending index (bit 7 highest) through a valid/ready handshake.
- Clears each pending bit when its index is handed off; sits between raw event sources and the downstream dispatch or service logic.

Parameters:
- N, 8, number of request lines.
- IDX_W, 3, index width; must equal clog2(N).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_in  input  N  raw level requests, synchronous to clk.
- mask  input  N  1 = line blocked from selection; still captured into pending.
- out_idx  output  IDX_W  index of the presented request.
- out_valid  output  1  out_idx holds a valid request.
- out_ready  input  1  consumer accepts when out_valid && out_ready.
- pending  output  N  current sticky pending register (status).
- drop_pulse  output  1  one-cycle pulse: a new edge hit a line that was already pending.

Behaviour:
- Reset (rst=1 at a clk edge):
  - pending=0, req_q=0, out_valid=0, out_idx=0, drop_pulse=0, FSM=IDLE.
  - Reset wins over every other event in that cycle; any offer in flight is discarded.
  - req_q is cleared to 0, so a line held high through reset produces an edge on the first cycle after reset deasserts.
- Edge detect:
  - req_q <= req_in every cycle.
  - edge = req_in & ~req_q.
- Pending update each cycle: pending <= (pending & ~clr) | edge.
  - clr is the one-hot bit of the index loaded into the output register this cycle.
  - Set wins over clear: if an edge arrives on the line being loaded, the bit stays set and is serviced again later.
- drop_pulse <= |(edge & pending & ~clr). Registered, so it is high in the cycle after the edge.
- Selection:
  - cand = pending & ~mask, using the registered pending value.
  - sel = index of the highest set bit of cand; sel_any = |cand.
- FSM states: IDLE, OFFER.
  - IDLE: if sel_any, load out_idx <= sel, set clr, out_valid <= 1, go to OFFER. Otherwise stay.
  - OFFER with out_valid && out_ready:
    - if sel_any (evaluated on pending after the previous clear), load the next sel the same cycle and stay in OFFER. This gives back-to-back, one transfer per cycle.
    - else out_valid <= 0 and go to IDLE.
  - OFFER with !out_ready: out_idx and out_valid stay stable. A higher-priority arrival does not preempt an offer already presented.
- Latency: edge sampled at clock edge k gives pending at k+1 and out_valid at k+2 when idle. Throughput is 1 per cycle.
- Mask changes take effect on the next selection only. The presented index is never withdrawn.
- mask=all-ones: no selection, pending keeps accumulating.
- All-zero pending: out_valid=0, out_idx keeps its last value. Consumers ignore out_idx when out_valid=0.
- IDX_W arithmetic is unsigned. No wrap-around; the index range is 0..N-1.

Decomposition:
- Shared package irq_pkg holds:
  - IRQ_N=8, IRQ_IDX_W=3;
  - an FSM state typedef (IDLE, OFFER);
  - a function prio_enc returning {any, idx}, highest-index-first.
- One natural sub-module: prio_enc8, a combinational highest-bit-first encoder with an any-output. It is reused by other dispatch blocks.

Test Plan:
- Reset with req_in=8'hFF held through reset, then deassert rst: drop_pulse=0 on the first post-reset cycle. At k+2, out_idx=7, out_valid=1; pending=8'hFF until the first load, then drains in order 7,6,...,0.
- req_in 0→8'h24 in one cycle with out_ready=1, mask=0:
  - cycle+2: out_idx=5, valid=1.
  - cycle+3: out_idx=2.
  - cycle+4: valid=0, pending=0.
- Stall: pending 8'h81, out_ready=0 for 5 cycles → out_idx=7 stable, valid stays 1. A new edge on line 4 meanwhile must not preempt. After ready, the order is 4 then 0.
- Mask: pending 8'h0C, mask=8'h08 → only idx 2 is offered, pending=8'h08 remains. Clear mask → idx 3 is offered the next cycle.
- Drop: line 1 pending and masked, a second rising edge on req_in[1] → drop_pulse=1 for exactly one cycle, pending[1] stays 1.
- Set/clear collision: a new edge on line 6 in the same cycle idx 6 is loaded → pending[6]=1 afterward, and idx 6 is offered a second time.
